// File: rtl/array_pkg.sv
// Shared constants and helpers for the indexed storage array.
package array_pkg;

  localparam int DEFAULT_WIDTH   = 12;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_INDEX_W = 6;

  // Address bits needed to select one of depth entries; never zero.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/array_if.sv
// Put/get bus of the storage array; the requester drives master, the array is slave.
interface array_if
  import array_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int INDEX_W = DEFAULT_INDEX_W
);

  logic               put;
  logic [INDEX_W-1:0] p_index;
  logic [WIDTH-1:0]   p_val;
  logic               get;
  logic [INDEX_W-1:0] g_index;
  logic [WIDTH-1:0]   g_val;
  logic               g_valid;
  logic               err;

  modport master (
    output put, p_index, p_val, get, g_index,
    input  g_val, g_valid, err
  );

  modport slave (
    input  put, p_index, p_val, get, g_index,
    output g_val, g_valid, err
  );

endinterface

// File: rtl/array_storage.sv
// Entry registers with synchronous clear, one write port and one combinational read port.
module array_storage #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the entries must read as zero after reset, so the whole array is
  // cleared here; this rules out a RAM macro and builds it from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/array.sv
// Indexed storage array: range checks, write-first bypass and registered read outputs.
module array
  import array_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int INDEX_W = DEFAULT_INDEX_W
) (
  input logic   clk,
  input logic   rst,
  array_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  // One extra bit so DEPTH == 2**INDEX_W is still representable.
  localparam logic [INDEX_W:0] DEPTH_L = DEPTH[INDEX_W:0];

  logic             p_in_range;
  logic             g_in_range;
  logic             same_index;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] g_val_q;
  logic             g_valid_q;
  logic             err_q;

  assign p_in_range = {1'b0, bus.p_index} < DEPTH_L;
  assign g_in_range = {1'b0, bus.g_index} < DEPTH_L;
  assign same_index = bus.put && p_in_range && (bus.p_index == bus.g_index);

  array_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.put && p_in_range),
    .waddr (bus.p_index[AW-1:0]),
    .wdata (bus.p_val),
    .raddr (bus.g_index[AW-1:0]),
    .rdata (rdata)
  );

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so the order of statements below does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_val_q   <= '0;
      g_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      g_valid_q <= bus.get;
      err_q     <= (bus.put && !p_in_range) || (bus.get && !g_in_range);
      if (bus.get) begin
        if (!g_in_range)     g_val_q <= '0;
        else if (same_index) g_val_q <= bus.p_val;
        else                 g_val_q <= rdata;
      end
    end
  end

  assign bus.g_val   = g_val_q;
  assign bus.g_valid = g_valid_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_array.sv
// Self-checking bench for array: directed table, pattern sweep, corner sequences, random vs model.
module tb_array;
  import array_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_if #(.WIDTH(12), .INDEX_W(6)) a_if ();
  array_if #(.WIDTH(12), .INDEX_W(7)) b_if ();

  array #(.WIDTH(12), .DEPTH(64), .INDEX_W(6)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  array #(.WIDTH(12), .DEPTH(64), .INDEX_W(7)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        put;
    int          p_index;
    int          p_val;
    logic        get;
    int          g_index;
    int          exp_g_val;
    logic        exp_g_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.put = 1'b0; a_if.get = 1'b0; a_if.p_index = '0; a_if.g_index = '0; a_if.p_val = '0;
  endtask

  task automatic idle_b();
    b_if.put = 1'b0; b_if.get = 1'b0; b_if.p_index = '0; b_if.g_index = '0; b_if.p_val = '0;
  endtask

  task automatic check_b(input string tag, input int gv, input int vld, input int e);
    check({tag, ".g_val"}, int'(b_if.g_val), gv);
    check({tag, ".g_valid"}, int'(b_if.g_valid), vld);
    check({tag, ".err"}, int'(b_if.err), e);
  endtask

  // Reference model for the random phase: plain array of entries plus last read.
  int model_mem [64];
  int model_g;

  initial begin
    idle_a();
    idle_b();
    rst = 1'b1;
    tick();
    tick();
    check("reset.g_val", int'(a_if.g_val), 0);
    check("reset.g_valid", int'(a_if.g_valid), 0);
    check("reset.err", int'(a_if.err), 0);
    rst = 1'b0;

    // Directed table on the default-geometry instance.
    vecs.push_back('{0,  0,    0, 1,  5,    0, 1, 0});
    vecs.push_back('{1,  7, 4095, 1,  7, 4095, 1, 0});
    vecs.push_back('{0,  0,    0, 0,  0, 4095, 0, 0});
    vecs.push_back('{1, 63, 1234, 0,  0, 4095, 0, 0});
    vecs.push_back('{0,  0,    0, 1, 63, 1234, 1, 0});
    vecs.push_back('{1,  0, 2048, 1, 63, 1234, 1, 0});
    vecs.push_back('{0,  0,    0, 1,  0, 2048, 1, 0});
    vecs.push_back('{1, 63,    1, 1,  7, 4095, 1, 0});
    vecs.push_back('{0,  0,    0, 1, 63,    1, 1, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      a_if.put = vecs[i].put; a_if.p_index = 6'(vecs[i].p_index); a_if.p_val = 12'(vecs[i].p_val);
      a_if.get = vecs[i].get; a_if.g_index = 6'(vecs[i].g_index);
      tick();
      check($sformatf("vec%0d.g_val", i), int'(a_if.g_val), vecs[i].exp_g_val);
      check($sformatf("vec%0d.g_valid", i), int'(a_if.g_valid), int'(vecs[i].exp_g_valid));
      check($sformatf("vec%0d.err", i), int'(a_if.err), int'(vecs[i].exp_err));
    end
    idle_a();

    // Full sweep with the repeating 55,30,4095,0 pattern.
    for (int i = 0; i < 64; i++) begin
      int pat [4] = '{55, 30, 4095, 0};
      a_if.put = 1'b1; a_if.p_index = 6'(i); a_if.p_val = 12'(pat[i % 4]);
      tick();
    end
    idle_a();
    for (int i = 0; i < 64; i++) begin
      int pat [4] = '{55, 30, 4095, 0};
      a_if.get = 1'b1; a_if.g_index = 6'(i);
      tick();
      check($sformatf("sweep%0d.g_val", i), int'(a_if.g_val), pat[i % 4]);
      check($sformatf("sweep%0d.g_valid", i), int'(a_if.g_valid), 1);
    end
    idle_a();

    // Hold after a read of 4095 (index 2 holds 4095).
    a_if.get = 1'b1; a_if.g_index = 6'd2;
    tick();
    check("hold.read", int'(a_if.g_val), 4095);
    idle_a();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d.g_val", i), int'(a_if.g_val), 4095);
      check($sformatf("hold%0d.g_valid", i), int'(a_if.g_valid), 0);
    end

    // Reset clears a written entry.
    a_if.put = 1'b1; a_if.p_index = 6'd10; a_if.p_val = 12'd30;
    tick();
    idle_a();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_if.get = 1'b1; a_if.g_index = 6'd10;
    tick();
    check("rst_clear.g_val", int'(a_if.g_val), 0);
    check("rst_clear.g_valid", int'(a_if.g_valid), 1);
    idle_a();

    // Reset wins over a same-cycle put and get.
    a_if.put = 1'b1; a_if.p_index = 6'd9; a_if.p_val = 12'd77;
    a_if.get = 1'b1; a_if.g_index = 6'd9;
    rst = 1'b1;
    tick();
    check("rst_prio.g_valid", int'(a_if.g_valid), 0);
    check("rst_prio.g_val", int'(a_if.g_val), 0);
    rst = 1'b0;
    a_if.put = 1'b0;
    tick();
    check("rst_prio.discarded", int'(a_if.g_val), 0);
    idle_a();

    // Out-of-range accesses on the 7-bit-index instance.
    b_if.put = 1'b1; b_if.p_index = 7'd0; b_if.p_val = 12'd30;
    tick();
    check_b("oor_put0", 0, 0, 0);
    b_if.p_index = 7'd64; b_if.p_val = 12'd55;
    tick();
    check_b("oor_put64", 0, 0, 1);
    b_if.put = 1'b0; b_if.get = 1'b1; b_if.g_index = 7'd64;
    tick();
    check_b("oor_get64", 0, 1, 1);
    b_if.g_index = 7'd0;
    tick();
    check_b("oor_entry0", 30, 1, 0);
    b_if.put = 1'b1; b_if.p_index = 7'd127; b_if.p_val = 12'd1; b_if.get = 1'b0;
    tick();
    check_b("oor_put127", 30, 0, 1);
    idle_b();

    // Random traffic against the model, starting from a known reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    model_g = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, p, g;
      int pi, pv, gi, exp_err;
      r  = ($urandom_range(0, 39) == 0);
      p  = $urandom_range(0, 1) == 1;
      g  = $urandom_range(0, 1) == 1;
      pi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 63));
      gi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) gi = pi;
      pv = int'($urandom_range(0, 4095));
      rst = r;
      b_if.put = p; b_if.p_index = 7'(pi); b_if.p_val = 12'(pv);
      b_if.get = g; b_if.g_index = 7'(gi);
      tick();
      if (r) begin
        foreach (model_mem[i]) model_mem[i] = 0;
        model_g = 0;
        check_b($sformatf("rnd%0d.rst", n), 0, 0, 0);
      end else begin
        if (p && pi < 64) model_mem[pi] = pv;
        if (g) model_g = (gi < 64) ? model_mem[gi] : 0;
        exp_err = ((p && pi >= 64) || (g && gi >= 64)) ? 1 : 0;
        check_b($sformatf("rnd%0d", n), model_g, int'(g), exp_err);
      end
    end
    rst = 1'b0;
    idle_b();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
